// File: rtl/adc_scope_pkg.sv
// adc_scope_pkg
// Shared types and defaults for the scrolling-scope min/max decimator.
//   binner_state_e : binner sequencing (IDLE / FIRST / ACCUM)
//   bin_entry_t    : one completed bin at the default channel/width set
//   entry_width()  : flattened FIFO entry width for any parameter set
package adc_scope_pkg;

    localparam int NCH_DEF   = 4;
    localparam int W_DEF     = 12;
    localparam int CMP_W_DEF = 11;
    localparam int OUT_W_DEF = 8;
    localparam int CNT_W_DEF = 16;

    // FIRST means "bin is empty, next strobe opens it"; ACCUM means the bin
    // holds at least one sample.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        ACCUM = 2'd2
    } binner_state_e;

    // Field order matches the flattened FIFO word: {min, max, count}.
    typedef struct packed {
        logic [NCH_DEF*OUT_W_DEF-1:0] bin_min;
        logic [NCH_DEF*OUT_W_DEF-1:0] bin_max;
        logic [CNT_W_DEF-1:0]         bin_count;
    } bin_entry_t;

    function automatic int entry_width(input int nch, input int out_w, input int cnt_w);
        return 2 * nch * out_w + cnt_w;
    endfunction

endpackage

// File: rtl/minmax_fifo.sv
// minmax_fifo
// First-word-fall-through synchronous FIFO holding completed bins.
// The head entry is visible on dout whenever empty is low; a push into a
// full FIFO is accepted only when a pop happens in the same cycle.
//   clock, reset : clock and synchronous active-high reset
//   push, din    : write request and data
//   pop          : consume the head entry (ignored when empty)
//   dout         : head entry
//   full, empty  : occupancy flags
module minmax_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage is cleared on reset so the head reads zero until the first push.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/adc_minmax_binner.sv
// adc_minmax_binner
// Multi-channel min/max decimator. Strobed ADC samples are folded into bins
// that close either after bin_len samples (mode 0) or on a frame sync edge
// (mode 1). Completed bins go to a FWFT FIFO with a valid/ready interface;
// bins that find the FIFO full are counted in drop_cnt.
//   ad_clk, reset     : sample clock, synchronous active-high reset
//   ad_strobe/ad_data : sample qualifier and NCH packed samples
//   sync_in           : asynchronous frame sync
//   enable, mode      : binning enable, 0 = fixed count, 1 = sync-closed
//   bin_len           : samples per bin in mode 0 (0 behaves as 1)
//   m_valid/m_ready   : output handshake; m_min/m_max/m_count bin contents
//   drop_cnt          : saturating count of dropped bins
module adc_minmax_binner
    import adc_scope_pkg::*;
#(
    parameter int NCH        = NCH_DEF,
    parameter int W          = W_DEF,
    parameter int CMP_W      = CMP_W_DEF,
    parameter int OUT_W      = OUT_W_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 ad_clk,
    input  logic                 reset,
    input  logic                 ad_strobe,
    input  logic [NCH*W-1:0]     ad_data,
    input  logic                 sync_in,
    input  logic                 enable,
    input  logic                 mode,
    input  logic [CNT_W-1:0]     bin_len,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [NCH*OUT_W-1:0] m_min,
    output logic [NCH*OUT_W-1:0] m_max,
    output logic [CNT_W-1:0]     m_count,
    output logic [15:0]          drop_cnt
);

    localparam int SHIFT   = CMP_W - OUT_W;
    localparam int ENTRY_W = entry_width(NCH, OUT_W, CNT_W);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    binner_state_e        state, state_next;
    logic [2:0]           sync_q;
    logic                 sync_edge;
    logic                 sync_pend, sync_pend_next;
    logic                 bin_mode, bin_mode_next;
    logic [CNT_W-1:0]     bin_len_q, bin_len_next;
    logic [CNT_W-1:0]     bin_count, bin_count_next;
    logic [NCH*CMP_W-1:0] run_min, run_min_next, run_max, run_max_next;
    logic [NCH*CMP_W-1:0] samp, fold_min, fold_max;
    logic [NCH*OUT_W-1:0] samp_o, fold_min_o, fold_max_o, run_min_o, run_max_o;
    logic                 push_req;
    logic [NCH*OUT_W-1:0] push_min, push_max;
    logic [CNT_W-1:0]     push_count;
    logic [ENTRY_W-1:0]   push_entry, head;
    logic                 fifo_full, fifo_empty, pop, drop;

    assign sync_edge = sync_q[1] && !sync_q[2];

    // Only the low CMP_W bits of each sample take part in comparisons; the
    // running extremes keep full compare precision and are truncated to the
    // top OUT_W bits of that field only when a bin is pushed.
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [CMP_W-1:0] s, mn, mx;
        logic             unused_hi;

        assign unused_hi = ^ad_data[c*W+CMP_W +: (W-CMP_W)];
        assign s  = ad_data[c*W +: CMP_W];
        assign mn = run_min[c*CMP_W +: CMP_W];
        assign mx = run_max[c*CMP_W +: CMP_W];

        assign samp[c*CMP_W +: CMP_W]     = s;
        assign fold_min[c*CMP_W +: CMP_W] = (s < mn) ? s : mn;
        assign fold_max[c*CMP_W +: CMP_W] = (s > mx) ? s : mx;

        assign samp_o[c*OUT_W +: OUT_W]     = s[SHIFT +: OUT_W];
        assign fold_min_o[c*OUT_W +: OUT_W] = fold_min[c*CMP_W+SHIFT +: OUT_W];
        assign fold_max_o[c*OUT_W +: OUT_W] = fold_max[c*CMP_W+SHIFT +: OUT_W];
        assign run_min_o[c*OUT_W +: OUT_W]  = mn[SHIFT +: OUT_W];
        assign run_max_o[c*OUT_W +: OUT_W]  = mx[SHIFT +: OUT_W];
    end

    // Bin sequencing. A closing bin is pushed in the same cycle as the strobe
    // that closes it, so the entry is assembled from the folded values here.
    // Sync pending accumulates edges between strobes and is consumed by the
    // next strobe; disabling discards the open bin without pushing it.
    always_comb begin
        state_next     = state;
        sync_pend_next = sync_pend || sync_edge;
        bin_mode_next  = bin_mode;
        bin_len_next   = bin_len_q;
        bin_count_next = bin_count;
        run_min_next   = run_min;
        run_max_next   = run_max;
        push_req       = 1'b0;
        push_min       = samp_o;
        push_max       = samp_o;
        push_count     = CNT_ONE;

        if (!enable) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    state_next     = FIRST;
                    sync_pend_next = 1'b0;
                end
                FIRST: begin
                    if (ad_strobe) begin
                        run_min_next   = samp;
                        run_max_next   = samp;
                        bin_count_next = CNT_ONE;
                        bin_mode_next  = mode;
                        bin_len_next   = bin_len;
                        sync_pend_next = sync_edge;
                        if (!mode && (bin_len <= CNT_ONE)) begin
                            push_req = 1'b1;
                        end else begin
                            state_next = ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (ad_strobe) begin
                        sync_pend_next = sync_edge;
                        if (!bin_mode) begin
                            run_min_next   = fold_min;
                            run_max_next   = fold_max;
                            bin_count_next = bin_count + CNT_ONE;
                            if ((bin_count + CNT_ONE) == bin_len_q) begin
                                push_req   = 1'b1;
                                push_min   = fold_min_o;
                                push_max   = fold_max_o;
                                push_count = bin_count + CNT_ONE;
                                state_next = FIRST;
                            end
                        end else if (sync_pend) begin
                            push_req       = 1'b1;
                            push_min       = run_min_o;
                            push_max       = run_max_o;
                            push_count     = bin_count;
                            run_min_next   = samp;
                            run_max_next   = samp;
                            bin_count_next = CNT_ONE;
                        end else begin
                            run_min_next   = fold_min;
                            run_max_next   = fold_max;
                            bin_count_next = (&bin_count) ? bin_count : bin_count + CNT_ONE;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Binner state, sync synchroniser and the saturating drop counter.
    always_ff @(posedge ad_clk) begin
        if (reset) begin
            state     <= IDLE;
            sync_q    <= '0;
            sync_pend <= 1'b0;
            bin_mode  <= 1'b0;
            bin_len_q <= '0;
            bin_count <= '0;
            run_min   <= '0;
            run_max   <= '0;
            drop_cnt  <= '0;
        end else begin
            state     <= state_next;
            sync_q    <= {sync_q[1:0], sync_in};
            sync_pend <= sync_pend_next;
            bin_mode  <= bin_mode_next;
            bin_len_q <= bin_len_next;
            bin_count <= bin_count_next;
            run_min   <= run_min_next;
            run_max   <= run_max_next;
            if (drop && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    assign pop        = m_valid && m_ready;
    assign drop       = push_req && fifo_full && !pop;
    assign push_entry = {push_min, push_max, push_count};
    assign m_valid    = !fifo_empty;
    assign {m_min, m_max, m_count} = head;

    minmax_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (ad_clk),
        .reset (reset),
        .push  (push_req),
        .pop   (pop),
        .din   (push_entry),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule
